// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with write bypass, hardwired x0,
// pending scoreboard and a post-reset sequencer that clears the array and loads sp.
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int AW = $clog2(NREGS),
  parameter int NUM_RD = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0001_0000)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   we,
  input  logic [AW-1:0]          addr_rd,
  input  logic [XLEN-1:0]        data_rd,
  input  logic [NUM_RD*AW-1:0]   addr_rs,
  output logic [NUM_RD*XLEN-1:0] data_rs,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic [NUM_RD-1:0]      pending_rs
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic run;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] pending, pending_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= INIT;
    else state <= state_nxt;
  always_comb state_nxt = (state == INIT && cnt == AW'(NREGS - 1)) ? RUN : state;
  always_comb begin
    run = state == RUN;
    ready = run;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!run) cnt <= cnt + 1'b1;
  // No reset on the array: the INIT sweep is what clears it.
  always_ff @(posedge clk)
    if (!run) mem[cnt] <= cnt == AW'(2) ? SP_INIT : '0;
    else if (we && addr_rd != '0) mem[addr_rd] <= data_rd;
  // Set after clear so a new producer wins over a retiring one.
  always_comb
    pending_nxt = ((pending & ~({NREGS{we}} & (NREGS'(1) << addr_rd)))
                  | ({NREGS{issue_en}} & (NREGS'(1) << issue_rd))) & ~NREGS'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) pending <= '0;
    else if (run) pending <= pending_nxt;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    always_comb begin
      a = addr_rs[k*AW +: AW];
      data_rs[k*XLEN +: XLEN] = (!run || a == '0) ? '0 : (we && addr_rd == a) ? data_rd : mem[a];
      pending_rs[k] = pending[a];
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against a
// behavioural array model, plus a 4-port 64-bit 16-register build.
module tb_reg_file_mp;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic        ready, we, issue_en;
  logic [4:0]  addr_rd, issue_rd;
  logic [31:0] data_rd;
  logic [9:0]  addr_rs;
  logic [63:0] data_rs;
  logic [1:0]  pending_rs;

  logic        ready4, we4, issue_en4;
  logic [3:0]  addr_rd4, issue_rd4;
  logic [63:0] data_rd4;
  logic [15:0] addr_rs4;
  logic [255:0] data_rs4;
  logic [3:0]  pending_rs4;

  reg_file_mp dut (
    .clk(clk), .reset(reset), .ready(ready), .we(we), .addr_rd(addr_rd),
    .data_rd(data_rd), .addr_rs(addr_rs), .data_rs(data_rs),
    .issue_en(issue_en), .issue_rd(issue_rd), .pending_rs(pending_rs)
  );

  reg_file_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4)) dut4 (
    .clk(clk), .reset(reset), .ready(ready4), .we(we4), .addr_rd(addr_rd4),
    .data_rd(data_rd4), .addr_rs(addr_rs4), .data_rs(data_rs4),
    .issue_en(issue_en4), .issue_rd(issue_rd4), .pending_rs(pending_rs4)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem_m [32];
  logic        pend_m [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    return a == 0 ? 32'h0 : (we && addr_rd == a) ? data_rd : mem_m[a];
  endfunction

  initial begin
    we = 0; addr_rd = 0; data_rd = 0; addr_rs = 0; issue_en = 0; issue_rd = 0;
    we4 = 0; addr_rd4 = 0; data_rd4 = 0; addr_rs4 = 0; issue_en4 = 0; issue_rd4 = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_pending", pending_rs, 0);
    addr_rs = {5'd2, 5'd2};
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("init_ready", ready, i == 31);
      chk("init_ready4", ready4, i >= 15);
      if (i == 3) chk("init_reads_zero", data_rs, 0);
    end
    for (int i = 0; i < 32; i++) begin mem_m[i] = 0; pend_m[i] = 0; end
    mem_m[2] = 32'h0001_0000;
    @(negedge clk); addr_rs = {5'd2, 5'd1}; #1;
    chk("x1_init", data_rs[31:0], 0);
    chk("x2_sp", data_rs[63:32], 32'h0001_0000);
    addr_rs = {5'd31, 5'd2}; #1;
    chk("x31_init", data_rs[63:32], 0);
    // same-cycle bypass then stored value
    @(negedge clk); we = 1; addr_rd = 5; data_rd = 32'hDEADBEEF; addr_rs = {5'd0, 5'd5}; #1;
    chk("bypass_x5", data_rs[31:0], 32'hDEADBEEF);
    @(negedge clk); we = 0; #1;
    chk("stored_x5", data_rs[31:0], 32'hDEADBEEF);
    mem_m[5] = 32'hDEADBEEF;
    @(negedge clk); we = 1; addr_rd = 0; data_rd = 32'hFFFFFFFF; addr_rs = 0; #1;
    chk("x0_bypass", data_rs, 0);
    @(negedge clk); we = 0; issue_en = 1; issue_rd = 0; #1;
    chk("x0_after", data_rs, 0);
    @(negedge clk); issue_en = 0; #1;
    chk("x0_pending", pending_rs, 0);
    @(negedge clk); issue_en = 1; issue_rd = 7; addr_rs = {5'd7, 5'd0}; #1;
    chk("pend7_not_yet", pending_rs[1], 0);
    @(negedge clk); issue_en = 0; #1;
    chk("pend7_set", pending_rs[1], 1);
    @(negedge clk); we = 1; addr_rd = 7; data_rd = 32'h77; issue_en = 1; issue_rd = 7; #1;
    chk("pend7_bypass", data_rs[63:32], 32'h77);
    chk("pend7_no_comb_clear", pending_rs[1], 1);
    @(negedge clk); issue_en = 0; #1;
    chk("pend7_set_wins", pending_rs[1], 1);
    @(negedge clk); we = 0; #1;
    chk("pend7_cleared", pending_rs[1], 0);
    mem_m[7] = 32'h77;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we = $urandom_range(1, 0) == 1; addr_rd = 5'($urandom); data_rd = $urandom;
      issue_en = $urandom_range(2, 0) == 0; issue_rd = 5'($urandom);
      addr_rs = 10'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("rand_data", data_rs[k*32 +: 32], exp_rd(addr_rs[k*5 +: 5]));
        chk("rand_pend", pending_rs[k], pend_m[addr_rs[k*5 +: 5]]);
      end
      @(posedge clk);
      if (we && addr_rd != 0) mem_m[addr_rd] = data_rd;
      if (we) pend_m[addr_rd] = 0;
      if (issue_en) pend_m[issue_rd] = 1;
      pend_m[0] = 0;
    end
    @(negedge clk); we = 0; issue_en = 0;
    for (int n = 1; n < 16; n++) begin
      @(negedge clk); we4 = 1; addr_rd4 = 4'(n); data_rd4 = 64'hA5A5_0000_0000_0000 | 64'(n);
    end
    @(negedge clk); we4 = 0;
    for (int g = 0; g < 4; g++) begin
      addr_rs4 = {4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)}; #1;
      for (int k = 0; k < 4; k++)
        chk("wide_port", data_rs4[k*64 +: 64],
            (4*g+k) == 0 ? 64'h0 : 64'hA5A5_0000_0000_0000 | 64'(4*g+k));
    end
    @(negedge clk); we = 1; addr_rd = 10; data_rd = 32'h1234; issue_en = 1; issue_rd = 10;
    @(negedge clk); we = 0; issue_en = 0; addr_rs = {5'd10, 5'd10}; #1;
    chk("x10_written", data_rs[31:0], 32'h1234);
    chk("x10_pending", pending_rs, 2'b11);
    @(negedge clk); we = 1; data_rd = 32'hFFFF; reset = 1; #1;
    chk("async_ready", ready, 0);
    chk("async_pending", pending_rs, 0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("reinit_ready", ready, i == 31);
      chk("reinit_ready4", ready4, i >= 15);
    end
    we = 0; #1;
    chk("x10_cleared", data_rs, 0);
    chk("x10_pend_cleared", pending_rs, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
